// File: rtl/fifo_rd_ctrl.sv
// Reader-side FIFO controller: pops on !fifo_empty, absorbs the one-cycle read latency in a
// 2-entry skid buffer and presents words on valid/ready. RDC_STATS_EN adds pop/stall counters.
module fifo_rd_ctrl #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [DT_WIDTH-1:0] fifo_rd_dt,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DT_WIDTH-1:0] out_dt,
  output logic                busy
`ifdef RDC_STATS_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          occ_reg, occ_next;
  logic                inflt_reg;
  logic [DT_WIDTH-1:0] head_reg, tail_reg;
  logic                pop;
  logic                wr;
  logic [1:0]          wr_pos;
  logic [2:0]          level;

  assign out_vld = !rst && (occ_reg != 2'd0) && (state_reg != FLUSH);
  assign pop     = out_vld & out_rdy;
  assign wr      = inflt_reg & (state_reg != FLUSH);
  assign out_dt  = head_reg;
  assign busy    = !rst && ((occ_reg != 2'd0) || inflt_reg || (state_reg == FLUSH));

  // Words already owed to the buffer after this edge; a read is legal only if one slot stays free.
  assign level      = {1'b0, occ_reg} + {2'b00, inflt_reg} - {2'b00, pop};
  assign fifo_rd_en = !rst && (state_reg == RUN) && en && !flush && !fifo_empty
                      && (level < 3'd2);

  assign wr_pos   = occ_reg - {1'b0, pop};
  assign occ_next = occ_reg + {1'b0, wr} - {1'b0, pop};

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state_reg)
        IDLE:    if (en) state_next = RUN;
        RUN:     if (!en) state_next = IDLE;
        FLUSH:   if (!inflt_reg) state_next = en ? RUN : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      occ_reg   <= 2'd0;
      inflt_reg <= 1'b0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      inflt_reg <= fifo_rd_en;
      if (flush) begin
        // Buffered and arriving words are dropped; data registers keep their last value.
        occ_reg <= 2'd0;
      end else begin
        occ_reg <= occ_next;
        if (pop && (occ_reg == 2'd2)) head_reg <= tail_reg;
        if (wr && (wr_pos == 2'd0)) head_reg <= fifo_rd_dt;
        if (wr && (wr_pos == 2'd1)) tail_reg <= fifo_rd_dt;
      end
    end
  end

`ifdef RDC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_cnt    <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if ((state_reg == RUN) && (occ_reg == 2'd0) && !inflt_reg && fifo_empty
          && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model with registered read, scoreboard of read-but-undelivered
// words (cleared by flush/reset), scenario tasks with inline checks.
module tb_fifo_rd_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, flush, out_rdy;
  logic         fifo_empty, fifo_rd_en, out_vld, busy;
  logic [W-1:0] fifo_rd_dt = '0;
  logic [W-1:0] out_dt;
`ifdef RDC_STATS_EN
  logic [15:0]  rd_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DT_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rd_dt (fifo_rd_dt),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_dt     (out_dt),
    .busy       (busy)
`ifdef RDC_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // FIFO model: storage plus pointers, one-cycle registered read.
  logic [W-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_dt <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Reference: every word popped from the FIFO is owed downstream in order, unless a flush
  // or reset intervenes before it is delivered.
  logic [W-1:0] pend_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int spurious = 0;
  int rd_empty_viol = 0;
  int occ_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
    end else begin
      if (out_vld && out_rdy) begin
        got_q.push_back(out_dt);
        if (pend_q.size() == 0) spurious++;
        else exp_q.push_back(pend_q.pop_front());
      end
      if (flush) pend_q.delete();
      if (fifo_rd_en) begin
        if (fifo_empty) rd_empty_viol++;
        else pend_q.push_back(mem[rd_ptr]);
      end
    end
    if (dut.occ_reg > 2'd2) occ_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    int k;
    en = 1'b1;
    out_rdy = 1'b1;
    k = 0;
    @(negedge clk);
    while ((!fifo_empty || busy) && k < 400) begin
      tick();
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_bad++;
      $display("FAIL drain_timeout: cycles %0d required below 400", k);
    end
    en = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_rdy = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_dt !== 8'h00) begin n_bad++; $display("FAIL reset_out_dt: got %h want 00", out_dt); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] exp_rd;
    logic [7:0] exp_vld;
    logic [W-1:0] want;
    clear_logs();
    for (int i = 0; i < 4; i++) push(W'(32'h11 + i));
    exp_rd  = 8'b0001_1110;
    exp_vld = 8'b0111_1000;
    en = 1'b1; out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_rd_en !== exp_rd[c]) begin n_bad++; $display("FAIL stream_rd_en c%0d: got %b want %b", c, fifo_rd_en, exp_rd[c]); end
      n_cmp++;
      if (out_vld !== exp_vld[c]) begin n_bad++; $display("FAIL stream_out_vld c%0d: got %b want %b", c, out_vld, exp_vld[c]); end
      if (exp_vld[c]) begin
        want = W'(32'h11 + c - 3);
        n_cmp++;
        if (out_dt !== want) begin n_bad++; $display("FAIL stream_out_dt c%0d: got %h want %h", c, out_dt, want); end
      end
      tick();
    end
    en = 1'b0;
    tick(); tick();
    n_cmp++;
    if (got_q.size() != 4) begin n_bad++; $display("FAIL stream_count: got %0d want 4", got_q.size()); end
  endtask

  task automatic test_backpressure();
    int nrd;
    logic [W-1:0] want;
    clear_logs();
    for (int i = 0; i < 8; i++) push(W'(32'hA0 + i));
    en = 1'b1; out_rdy = 1'b0; nrd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (c >= 3) begin
        n_cmp++;
        if (out_vld !== 1'b1 || out_dt !== 8'hA0) begin
          n_bad++; $display("FAIL stall_hold c%0d: got vld=%b dt=%h want vld=1 dt=a0", c, out_vld, out_dt);
        end
      end
      tick();
    end
    n_cmp++;
    if (nrd != 2) begin n_bad++; $display("FAIL stall_reads: got %0d want 2", nrd); end
    drain();
    n_cmp++;
    if (got_q.size() != 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      want = W'(32'hA0 + i);
      $display("txn stall[%0d] dt=%h", i, got_q[i]);
      n_cmp++;
      if (got_q[i] !== want) begin n_bad++; $display("FAIL stall_word[%0d]: got %h want %h", i, got_q[i], want); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] src_q[$];
    logic [W-1:0] v;
    int pushed;
    int k;
    clear_logs();
    pushed = 0; k = 0;
    en = 1'b1;
    while (got_q.size() < 200 && k < 5000) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        v = W'($urandom);
        push(v);
        src_q.push_back(v);
        pushed++;
      end
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 5000) begin n_bad++; $display("FAIL random_timeout: delivered %0d want 200", got_q.size()); end
    en = 1'b0; out_rdy = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (got_q.size() != 200) begin n_bad++; $display("FAIL random_count: got %0d want 200", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < src_q.size(); i++) begin
      $display("txn random[%0d] dt=%h", i, got_q[i]);
      n_cmp++;
      if (got_q[i] !== src_q[i]) begin n_bad++; $display("FAIL random_word[%0d]: got %h want %h", i, got_q[i], src_q[i]); end
    end
    n_cmp++; if (occ_viol != 0) begin n_bad++; $display("FAIL occ_overflow: got %0d events want 0", occ_viol); end
    n_cmp++; if (rd_empty_viol != 0) begin n_bad++; $display("FAIL read_when_empty: got %0d events want 0", rd_empty_viol); end
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL spurious_out: got %0d events want 0", spurious); end
  endtask

  task automatic test_flush();
    logic [W-1:0] want;
    clear_logs();
    for (int i = 0; i < 10; i++) push(W'(32'hB0 + i));
    en = 1'b1; out_rdy = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || out_vld !== 1'b1 || fifo_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL flush_entry: got busy=%b vld=%b rd=%b want 1 1 0", busy, out_vld, fifo_rd_en);
    end
    tick();
    flush = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_vld !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL flush_state: got vld=%b rd=%b busy=%b want 0 0 1", out_vld, fifo_rd_en, busy);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (out_vld !== 1'b0 || fifo_rd_en !== 1'b1) begin
      n_bad++; $display("FAIL flush_resume: got vld=%b rd=%b want 0 1", out_vld, fifo_rd_en);
    end
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if (out_vld !== 1'b1 || out_dt !== 8'hB2) begin
      n_bad++; $display("FAIL flush_next_word: got vld=%b dt=%h want 1 b2", out_vld, out_dt);
    end
    tick();
    drain();
    n_cmp++;
    if (got_q.size() != 8) begin n_bad++; $display("FAIL flush_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      want = W'(32'hB2 + i);
      $display("txn flush[%0d] dt=%h", i, got_q[i]);
      n_cmp++;
      if (got_q[i] !== want || got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL flush_word[%0d]: got %h want %h", i, got_q[i], want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] want;
    clear_logs();
    for (int i = 0; i < 10; i++) push(W'(32'hC0 + i));
    en = 1'b1; out_rdy = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_vld !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL in_reset_outputs: got vld=%b rd=%b busy=%b want 0 0 0", out_vld, fifo_rd_en, busy);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_vld !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || out_dt !== 8'h00) begin
      n_bad++; $display("FAIL after_reset_outputs: got vld=%b rd=%b busy=%b dt=%h want 0 0 0 00", out_vld, fifo_rd_en, busy, out_dt);
    end
    tick();
    drain();
    n_cmp++;
    if (got_q.size() != 8) begin n_bad++; $display("FAIL rstmid_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      want = (i == 0) ? 8'hC0 : W'(32'hC3 + i - 1);
      $display("txn rstmid[%0d] dt=%h", i, got_q[i]);
      n_cmp++;
      if (got_q[i] !== want) begin n_bad++; $display("FAIL rstmid_word[%0d]: got %h want %h", i, got_q[i], want); end
    end
  endtask

`ifdef RDC_STATS_EN
  task automatic test_stats();
    rst = 1'b1; en = 1'b0; out_rdy = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) push(W'(32'hD0 + i));
    en = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    en = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    n_cmp++; if (rd_cnt !== 16'd10) begin n_bad++; $display("FAIL stats_rd_cnt: got %0d want 10", rd_cnt); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_stall_cnt: got %0d want 3", stall_cnt); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rd_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL stats_flush_clear: got rd=%0d stall=%0d want 0 0", rd_cnt, stall_cnt);
    end
    tick(); tick();
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
`ifdef RDC_STATS_EN
    test_stats();
`endif
    n_cmp++;
    if (spurious != 0 || rd_empty_viol != 0 || occ_viol != 0) begin
      n_bad++; $display("FAIL final_invariants: got spurious=%0d rd_empty=%0d occ=%0d want 0 0 0", spurious, rd_empty_viol, occ_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
